// File: rtl/arrow_generator.sv
// Per-beat pseudo-random arrow code source with lead-in blanking and an anti-repeat rule.
// Define ARROW_GEN_NO_COMBO_EN to restrict draws to the single-arrow codes 10..13.
module arrow_generator #(
    parameter int          STATE_BITS = 1,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          LEAD_IN    = 4,
    parameter int          MAX_REPEAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                metronome_clk,
    input  logic [STATE_BITS:0] state,
    output logic [4:0]          next_arrow,
    output logic                beat,
    output logic [15:0]         arrow_count
);

    localparam logic [STATE_BITS:0] ST_GAME  = (STATE_BITS + 1)'(0);
    localparam logic [STATE_BITS:0] ST_RESET = (STATE_BITS + 1)'(2);
    localparam logic [4:0]  ARROW_NONE = 5'd20;
    localparam logic [4:0]  ARROW_MIN  = 5'd10;
`ifdef ARROW_GEN_NO_COMBO_EN
    localparam logic [4:0]  ARROW_MAX  = 5'd13;
`else
    localparam logic [4:0]  ARROW_MAX  = 5'd19;
`endif
    localparam logic [7:0]  LEAD_INIT  = 8'(LEAD_IN);
    localparam logic [7:0]  REP_LIM    = 8'(MAX_REPEAT - 1);

    logic [2:0]  sync_q;
    logic        tick_q;
    logic [15:0] lfsr_q, lfsr_d;
    logic [4:0]  arrow_q;
    logic        beat_q;
    logic [15:0] count_q;
    logic [7:0]  lead_q;
    logic [7:0]  rep_q, rep_d;
    logic [3:0]  k;
    logic [4:0]  raw_code, rot_code, code_d;

    // Draw and anti-repeat resolve combinationally from current state; one register stage to output.
    always_comb begin
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400);
        k        = lfsr_q[5:2];
        raw_code = ARROW_NONE;
        if (lfsr_q[5:0] < 6'd44 && k != 4'd10) begin
`ifdef ARROW_GEN_NO_COMBO_EN
            raw_code = ARROW_MIN + {3'b000, k[1:0]};
`else
            raw_code = ARROW_MIN + {1'b0, k};
`endif
        end
        rot_code = (raw_code == ARROW_MAX) ? ARROW_MIN : raw_code + 5'd1;
        code_d   = raw_code;
        if (raw_code != ARROW_NONE && raw_code == arrow_q && rep_q == REP_LIM)
            code_d = rot_code;
        rep_d = (code_d != ARROW_NONE && code_d == arrow_q) ? rep_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            tick_q  <= 1'b0;
            lfsr_q  <= SEED;
            arrow_q <= ARROW_NONE;
            beat_q  <= 1'b0;
            count_q <= '0;
            lead_q  <= LEAD_INIT;
            rep_q   <= '0;
        end else begin
            sync_q <= {sync_q[1:0], metronome_clk};
            tick_q <= sync_q[1] & ~sync_q[2];
            lfsr_q <= lfsr_d;
            beat_q <= 1'b0;
            if (state == ST_RESET) begin
                arrow_q <= ARROW_NONE;
                count_q <= '0;
                lead_q  <= LEAD_INIT;
                rep_q   <= '0;
            end else if (state == ST_GAME && tick_q) begin
                beat_q <= 1'b1;
                // Lead-in blanks the beat and leaves the repeat history alone.
                if (lead_q != 8'd0) begin
                    arrow_q <= ARROW_NONE;
                    lead_q  <= lead_q - 8'd1;
                end else begin
                    arrow_q <= code_d;
                    rep_q   <= rep_d;
                    if (code_d != ARROW_NONE && count_q != 16'hFFFF)
                        count_q <= count_q + 16'd1;
                end
            end
        end
    end

    assign next_arrow  = arrow_q;
    assign beat        = beat_q;
    assign arrow_count = count_q;

endmodule

// File: tb/tb_arrow_generator.sv
// Scoreboard bench for arrow_generator: a reference model predicts each beat's code at stimulus time.
module tb_arrow_generator;
    localparam logic [15:0] SEED       = 16'hACE1;
    localparam int          LEAD_IN    = 4;
    localparam int          MAX_REPEAT = 2;
    localparam int          ST_GAME = 0, ST_PAUSE = 1, ST_RESET = 2;
`ifdef ARROW_GEN_NO_COMBO_EN
    localparam int          MAX_CODE = 13;
`else
    localparam int          MAX_CODE = 19;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        metronome_clk = 1'b0;
    logic [1:0]  state = 2'(ST_PAUSE);
    logic [4:0]  next_arrow;
    logic        beat;
    logic [15:0] arrow_count;

    arrow_generator dut (
        .clk(clk), .rst_n(rst_n), .metronome_clk(metronome_clk), .state(state),
        .next_arrow(next_arrow), .beat(beat), .arrow_count(arrow_count)
    );

    always #5 clk = ~clk;

    typedef struct { int code; int cnt; int cyc; } exp_t;
    exp_t q[$];
    exp_t mon_e;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int m_arrow, m_cnt, m_lead, m_rep;
    int shown, shown_cnt;
    bit stat_en = 0;
    int n_stat = 0, n_none = 0, n_bad = 0, run = 0, max_run = 0, last_code = 20;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic logic [15:0] step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int draw(input logic [15:0] l);
        int r = int'(l[5:0]);
        int k = r / 4;
        if (r >= 44 || k == 10) return 20;
`ifdef ARROW_GEN_NO_COMBO_EN
        return 10 + k % 4;
`else
        return 10 + k;
`endif
    endfunction

    function automatic int rotate(input int c);
        return 10 + (c - 9) % (MAX_CODE - 9);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= step(m_lfsr);

    task automatic model_reset();
        m_arrow = 20; m_cnt = 0; m_lead = LEAD_IN; m_rep = 0;
        shown = 20; shown_cnt = 0;
    endtask

    // One metronome period: 8 high, 8+gap low. Expected result is pushed at the rising edge.
    task automatic beat_once(input int gap);
        exp_t e;
        int   code;
        bit   pushed = 0;
        @(negedge clk);
        metronome_clk = 1'b1;
        if (int'(state) == ST_GAME) begin
            if (m_lead > 0) begin
                code = 20;
                m_lead--;
            end else begin
                code = draw(step(step(step(m_lfsr))));
                if (code != 20 && code == m_arrow && m_rep == MAX_REPEAT - 1) code = rotate(code);
                m_rep = (code != 20 && code == m_arrow) ? m_rep + 1 : 0;
            end
            m_arrow = code;
            if (code != 20 && m_cnt < 65535) m_cnt++;
            e.code = code; e.cnt = m_cnt; e.cyc = cyc + 4;
            q.push_back(e);
            pushed = 1;
        end
        repeat (8) @(negedge clk);
        metronome_clk = 1'b0;
        repeat (8 + gap) @(negedge clk);
        if (pushed) chk("beat_seen", q.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (beat) begin
                if (q.size() == 0) chk("spurious_beat", 1, 0);
                else begin
                    mon_e = q.pop_front();
                    chk("code", int'(next_arrow), mon_e.code);
                    chk("count", int'(arrow_count), mon_e.cnt);
                    chk("latency", cyc, mon_e.cyc);
                    shown = mon_e.code; shown_cnt = mon_e.cnt;
                    if (stat_en) begin
                        n_stat++;
                        if (mon_e.code == 20) n_none++;
                        if (!(next_arrow == 5'd20 || (next_arrow >= 5'd10 && int'(next_arrow) <= MAX_CODE)))
                            n_bad++;
                        if (next_arrow != 5'd20 && int'(next_arrow) == last_code) run++;
                        else run = (next_arrow != 5'd20) ? 1 : 0;
                        if (run > max_run) max_run = run;
                        last_code = int'(next_arrow);
                    end
                end
            end else begin
                chk("hold", int'(next_arrow) * 65536 + int'(arrow_count), shown * 65536 + shown_cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d expected beats outstanding", q.size());
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_arrow", int'(next_arrow), 20);
        chk("rst_beat", int'(beat), 0);
        chk("rst_count", int'(arrow_count), 0);
        rst_n = 1'b1;
        state = 2'(ST_GAME);

        // Two lead-in beats, then rst_n must restart the full lead-in.
        repeat (2) beat_once(0);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("midlead_rst_arrow", int'(next_arrow), 20);
        rst_n = 1'b1;
        repeat (10) beat_once(int'($urandom_range(0, 3)));

        // PAUSE freezes everything; lead-in is not re-applied on return.
        state = 2'(ST_PAUSE);
        repeat (5) beat_once(int'($urandom_range(0, 3)));
        state = 2'(ST_GAME);
        repeat (3) beat_once(int'($urandom_range(0, 3)));

        // STATE_RESET mid-game for two cycles.
        state = 2'(ST_RESET);
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_arrow", int'(next_arrow), 20);
        chk("reset_count", int'(arrow_count), 0);
        state = 2'(ST_GAME);
        repeat (4) beat_once(int'($urandom_range(0, 3)));

        stat_en = 1;
        repeat (2000) beat_once(int'($urandom_range(0, 3)));
        stat_en = 0;

        chk("max_run_ok", int'(max_run <= MAX_REPEAT), 1);
        chk("legal_codes", n_bad, 0);
        chk("none_freq_ok", int'(n_none * 1000 >= 325 * n_stat && n_none * 1000 <= 425 * n_stat), 1);
        chk("q_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
